// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W   = 32;
  localparam int ADDR_LSB = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with write enable and a registered read (read-first).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // rdata only moves on an enabled access, so a pending response stays stable
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Latency-configurable load/store responder with valid/ready request and response channels.
// Optional misaligned-address rejection is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = WORD_W - ADDR_LSB;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam logic MISALIGN_CHECK = 1'b1;
`else
  localparam logic MISALIGN_CHECK = 1'b0;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              write_lat;
  logic              err_lat;
  logic [AW-1:0]     idx_lat;
  logic [WORD_W-1:0] wdata_lat;
  logic [WORD_W-1:0] rd_data;

  logic [IDX_W-1:0]  word_idx;
  logic              out_of_range;
  logic              misaligned;
  logic              req_err;
  logic              commit;

  assign word_idx     = req_addr[WORD_W-1:ADDR_LSB];
  assign out_of_range = (word_idx >= IDX_W'(DEPTH));
  assign misaligned   = |req_addr[ADDR_LSB-1:0];
  assign req_err      = out_of_range | (MISALIGN_CHECK & misaligned);

  // Rejected accesses never touch the array, so an erroring store cannot corrupt it
  assign commit = (state == BUSY) && (cnt == '0) && !err_lat;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .en    (commit),
    .we    (write_lat),
    .addr  (idx_lat),
    .wdata (wdata_lat),
    .rdata (rd_data)
  );

  // Load data is shown only while a good load response is pending; zero otherwise
  assign rsp_rdata = (rsp_valid && !write_lat && !err_lat) ? rd_data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      write_lat <= 1'b0;
      err_lat   <= 1'b0;
      idx_lat   <= '0;
      wdata_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_lat <= req_write;
            err_lat   <= req_err;
            idx_lat   <= word_idx[AW-1:0];
            wdata_lat <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_lat;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven scoreboard bench for dmem_responder, plus reset-abort sequences.
module tb_dmem_responder;

  localparam int LAT = 2;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH   (256),
    .LATENCY (LAT),
    .CNT_W   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check1({tag, "_req_ready"}, req_ready, 1'b1);
    check1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check32({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check1({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  // Issue one request, scramble the request inputs while busy, and score the response
  task automatic run_txn(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clock);
    check1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clock);
    #1;
    sb.push_back('{v.exp_rdata, v.exp_err});
    check1("req_ready_busy", req_ready, 1'b0);
    req_write = ~v.write;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    req_valid = 1'b0;
    check32("latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clock);
      #1;
      check1("hold_rsp_valid", rsp_valid, 1'b1);
      check32("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
      check1("hold_req_ready", req_ready, 1'b0);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      check1("rsp_valid", rsp_valid, 1'b1);
      check32("rsp_rdata", rsp_rdata, e.rdata);
      check1("rsp_err", rsp_err, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    check_idle_outputs("after_take");
    $display("txn %s addr=0x%08h wdata=0x%08h exp_rdata=0x%08h exp_err=%b hold=%0d",
             v.write ? "ST" : "LD", v.addr, v.wdata, v.exp_rdata, v.exp_err, v.hold);
  endtask

  // Accept a store, then wait `cycles` edges and pulse reset asynchronously mid-cycle
  task automatic reset_during(input logic [31:0] addr, input logic [31:0] wdata, input int cycles);
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_async");
    @(negedge clock);
    reset = 1'b0;
    $display("reset pulse after %0d busy/resp cycles of store addr=0x%08h", cycles, addr);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 5};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0, 0};
    vecs[3]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,         1'b1, 0};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0, 0};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 2};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0,         1'b0, 0};
    vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D, 1'b0, 0};
    vecs[8]  = '{1'b0, 32'h0000_0013, 32'h0,         MIS ? 32'h0 : 32'hDEAD_BEEF, MIS, 1};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0,         1'b1, 0};
    vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D, 1'b0, 0};
    vecs[11] = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0,         1'b0, 0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_idle_outputs("idle");

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i]);
    end

    // Uncommitted store to 0x20 is discarded; the earlier value must survive
    reset_during(32'h0000_0020, 32'h1234_5678, 0);
    run_txn('{1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_A5A5, 1'b0, 0});

    // Store to 0x24 already committed (reset in RESP) must remain
    reset_during(32'h0000_0024, 32'h7777_7777, LAT);
    run_txn('{1'b0, 32'h0000_0024, 32'h0, 32'h7777_7777, 1'b0, 0});

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
